// File: rtl/fp16_pkg.sv
// Shared binary16 number model for the vertex-transform datapath (multiplier and adder).
// Implicit leading 1, bias 15, no denormals, [14:0]==0 is zero, truncation rounding.
package fp16_pkg;

    localparam logic signed [6:0] FP16_BIAS       = 7'sd15;
    localparam logic signed [6:0] FP16_EXP_MAX    = 7'sd30;
    localparam logic [14:0]       FP16_MAX_FINITE = 15'h7BFF;
    localparam logic [15:0]       FP16_ZERO       = 16'h0000;

    localparam int SIGN_BIT = 32'sd15;
    localparam int EXP_MSB  = 32'sd14;
    localparam int EXP_LSB  = 32'sd10;
    localparam int MAN_MSB  = 32'sd9;

    typedef logic [10:0]        fp16_sig_t;
    typedef logic [21:0]        fp16_prod_t;
    typedef logic signed [6:0]  fp16_exp_t;

    function automatic logic fp16_is_zero(input logic [15:0] x);
        return (x[EXP_MSB:0] == 15'd0);
    endfunction

    function automatic fp16_sig_t fp16_sig(input logic [15:0] x);
        return {1'b1, x[MAN_MSB:0]};
    endfunction

    // Unbiased-then-rebiased exponent of the raw significand product; range -15..47.
    function automatic fp16_exp_t fp16_exp_sum(input logic [15:0] a, input logic [15:0] b);
        return $signed({2'b00, a[EXP_MSB:EXP_LSB]}) + $signed({2'b00, b[EXP_MSB:EXP_LSB]}) - FP16_BIAS;
    endfunction

endpackage

// File: rtl/fp16_mul_normalize.sv
// Combinational stage-3 of the binary16 multiplier: normalize the 22-bit significand
// product, truncate, and pack with zero/underflow flush and overflow saturation.
module fp16_mul_normalize
    import fp16_pkg::*;
(
    input  logic [21:0]       prod,
    input  logic signed [6:0] es,
    input  logic              sign,
    input  logic              zero,
    output logic [15:0]       result
);

    logic signed [6:0] exp_s;
    logic [9:0]        man_s;
    logic              unused_s;

    assign unused_s = ^prod[9:0];

    // Select normalization shift from the product's top bit and pack the result.
    always_comb begin
        exp_s  = es;
        man_s  = prod[19:10];
        result = FP16_ZERO;
        if (prod[21]) begin
            exp_s = es + 7'sd1;
            man_s = prod[20:11];
        end else begin
            exp_s = es;
            man_s = prod[19:10];
        end

        if (zero) begin
            result = FP16_ZERO;
        end else if (exp_s <= 7'sd0) begin
            result = FP16_ZERO;
        end else if (exp_s > FP16_EXP_MAX) begin
            result = {sign, FP16_MAX_FINITE};
        end else begin
            result = {sign, exp_s[4:0], man_s};
        end
    end

endmodule

// File: rtl/multiplier_half_precision_pipe.sv
// 3-stage pipelined binary16 multiplier with valid/ready on both sides and a
// pass-through tag; bubbles collapse so an empty stage fills under backpressure.
module multiplier_half_precision_pipe
    import fp16_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [15:0]      i_Factor1,
    input  logic [15:0]      i_Factor2,
    input  logic [TAG_W-1:0] i_Tag,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [15:0]      o_Product,
    output logic [TAG_W-1:0] o_Tag
);

    logic en1_s, en2_s, en3_s;
    logic v1_r, v2_r, v3_r;

    logic              sign1_r, zero1_r;
    logic signed [6:0] es1_r;
    logic [10:0]       man_a1_r, man_b1_r;
    logic [TAG_W-1:0]  tag1_r;

    logic              sign2_r, zero2_r;
    logic signed [6:0] es2_r;
    logic [21:0]       prod2_r;
    logic [TAG_W-1:0]  tag2_r;

    logic [15:0]       result_s;

    assign en3_s   = !v3_r || i_Ready;
    assign en2_s   = !v2_r || en3_s;
    assign en1_s   = !v1_r || en2_s;
    assign o_Ready = en1_s;
    assign o_Valid = v3_r;

    // Stage 1: capture operands, classify sign/zero and form the exponent sum.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            v1_r     <= 1'b0;
            sign1_r  <= 1'b0;
            zero1_r  <= 1'b0;
            es1_r    <= 7'sd0;
            man_a1_r <= 11'd0;
            man_b1_r <= 11'd0;
            tag1_r   <= '0;
        end else if (en1_s) begin
            v1_r <= i_Valid;
            if (i_Valid) begin
                sign1_r  <= i_Factor1[SIGN_BIT] ^ i_Factor2[SIGN_BIT];
                zero1_r  <= fp16_is_zero(i_Factor1) || fp16_is_zero(i_Factor2);
                es1_r    <= fp16_exp_sum(i_Factor1, i_Factor2);
                man_a1_r <= fp16_sig(i_Factor1);
                man_b1_r <= fp16_sig(i_Factor2);
                tag1_r   <= i_Tag;
            end
        end
    end

    // Stage 2: full 11x11 significand multiply; classification rides along.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            v2_r    <= 1'b0;
            sign2_r <= 1'b0;
            zero2_r <= 1'b0;
            es2_r   <= 7'sd0;
            prod2_r <= 22'd0;
            tag2_r  <= '0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                sign2_r <= sign1_r;
                zero2_r <= zero1_r;
                es2_r   <= es1_r;
                prod2_r <= 22'(man_a1_r) * 22'(man_b1_r);
                tag2_r  <= tag1_r;
            end
        end
    end

    fp16_mul_normalize u_normalize (
        .prod   (prod2_r),
        .es     (es2_r),
        .sign   (sign2_r),
        .zero   (zero2_r),
        .result (result_s)
    );

    // Stage 3: output register; holds its value while the consumer stalls.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            v3_r      <= 1'b0;
            o_Product <= FP16_ZERO;
            o_Tag     <= '0;
        end else if (en3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                o_Product <= result_s;
                o_Tag     <= tag2_r;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_half_precision_pipe.sv
// Directed + randomized self-checking bench for multiplier_half_precision_pipe
// with a queue-based scoreboard and an arithmetic reference model.
module tb_multiplier_half_precision_pipe;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [15:0] i_Factor1 = 16'h0000;
    logic [15:0] i_Factor2 = 16'h0000;
    logic [3:0]  i_Tag = 4'd0;
    logic        o_Valid;
    logic        i_Ready = 1'b0;
    logic [15:0] o_Product;
    logic [3:0]  o_Tag;

    multiplier_half_precision_pipe #(.TAG_W(4)) dut (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Valid   (i_Valid),
        .o_Ready   (o_Ready),
        .i_Factor1 (i_Factor1),
        .i_Factor2 (i_Factor2),
        .i_Tag     (i_Tag),
        .o_Valid   (o_Valid),
        .i_Ready   (i_Ready),
        .o_Product (o_Product),
        .o_Tag     (o_Tag)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] stall_prod = 16'h0000;
    logic [3:0]  stall_tag = 4'd0;
    bit          last_acc = 1'b0;

    // Value = sigA*sigB * 2^(ea+eb-50); shift the product down to an 11-bit significand.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int    ea, eb, k, e;
        longint m;
        logic  s;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return 16'h0000;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        m  = longint'({1'b1, a[9:0]}) * longint'({1'b1, b[9:0]});
        k  = 0;
        while (m >= 64'sd2048) begin
            m = m >> 1;
            k++;
        end
        e = ea + eb - 25 + k;
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {s, 15'h7BFF};
        return {s, 5'(e), 10'(m - 64'sd1024)};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // One clock: drive inputs, score handshakes just before the edge, land on the next negedge.
    task automatic step(input logic rst, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expp, input logic [3:0] tag, input logic rdy);
        exp_t e;
        i_Reset = rst; i_Valid = v; i_Factor1 = a; i_Factor2 = b; i_Tag = tag; i_Ready = rdy;
        #1;
        last_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(o_Valid), 32'd1);
                chk("stall_product", 32'(o_Product), 32'(stall_prod));
                chk("stall_tag", 32'(o_Tag), 32'(stall_tag));
            end
            if (o_Valid && i_Ready) begin
                chk("emit_has_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("product", 32'(o_Product), 32'(e.p));
                    chk("tag", 32'(o_Tag), 32'(e.t));
                    if (lat_mode) chk("latency", 32'(cyc - e.c), 32'd3);
                end
            end
            if (i_Valid && o_Ready) begin
                e.p = expp; e.t = tag; e.c = cyc;
                exp_q.push_back(e);
                last_acc = 1'b1;
            end
            stall_prev = o_Valid && !i_Ready;
            stall_prod = o_Product;
            stall_tag  = o_Tag;
        end
        @(negedge i_Clk);
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, rdy);
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] x;
        if ($urandom_range(0, 7) == 0) begin
            x = {1'($urandom_range(0, 1)), 15'd0};
        end else begin
            x = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
        end
        return x;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [15:0] a, b;
        @(negedge i_Clk);
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0);
        i_Reset = 1'b0;
        #1;
        chk("reset_valid", 32'(o_Valid), 32'd0);
        chk("reset_product", 32'(o_Product), 32'h0);
        chk("reset_tag", 32'(o_Tag), 32'h0);
        chk("reset_ready", 32'(o_Ready), 32'd1);

        // basic latency: accepted pair must appear exactly three cycles later
        lat_mode = 1'b1;
        step(1'b0, 1'b1, 16'h3C00, 16'h4000, 16'h4000, 4'd1, 1'b1);
        chk("lat_c1_valid", 32'(o_Valid), 32'd0);
        idle(1'b1);
        chk("lat_c2_valid", 32'(o_Valid), 32'd0);
        idle(1'b1);
        chk("lat_c3_valid", 32'(o_Valid), 32'd1);
        chk("basic_product", 32'(o_Product), 32'h4000);
        chk("basic_tag", 32'(o_Tag), 32'd1);
        idle(1'b1);

        // back-to-back: carry, sign, zero, underflow, overflow, boundary
        step(1'b0, 1'b1, 16'h3E00, 16'h3E00, 16'h4080, 4'd2, 1'b1);
        step(1'b0, 1'b1, 16'hC200, 16'h3800, 16'hBE00, 4'd3, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 16'h4000, 16'h0000, 4'd4, 1'b1);
        step(1'b0, 1'b1, 16'h8000, 16'hC000, 16'h0000, 4'd5, 1'b1);
        step(1'b0, 1'b1, 16'h0400, 16'h0400, 16'h0000, 4'd6, 1'b1);
        step(1'b0, 1'b1, 16'h7800, 16'h4000, 16'h7BFF, 4'd7, 1'b1);
        step(1'b0, 1'b1, 16'hF800, 16'h4000, 16'hFBFF, 4'd8, 1'b1);
        step(1'b0, 1'b1, 16'h7800, 16'h3C00, 16'h7800, 4'd9, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("directed_drained", 32'(exp_q.size()), 32'd0);
        lat_mode = 1'b0;

        // backpressure: only three items fit while the consumer is stalled
        idx = 0;
        for (int s = 0; s < 6; s++) begin
            step(1'b0, 1'b1, 16'h3C00 | 16'(idx), 16'h4000, 16'h4000 | 16'(idx), 4'(idx), 1'b0);
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_ready_low", 32'(o_Ready), 32'd0);
        for (int s = 0; s < 40 && (idx < 6 || exp_q.size() != 0); s++) begin
            step(1'b0, 1'(idx < 6), 16'h3C00 | 16'(idx), 16'h4000, 16'h4000 | 16'(idx), 4'(idx), 1'b1);
            if (last_acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd6);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // reset with three items in flight discards them all
        for (int s = 0; s < 3; s++)
            step(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h4400, 4'(s), 1'b0);
        chk("mid_inflight", 32'(exp_q.size()), 32'd3);
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0);
        chk("mid_reset_valid", 32'(o_Valid), 32'd0);
        chk("mid_reset_product", 32'(o_Product), 32'h0);
        chk("mid_reset_ready", 32'(o_Ready), 32'd1);
        for (int s = 0; s < 6; s++) begin
            idle(1'b1);
            chk("no_stale_valid", 32'(o_Valid), 32'd0);
        end

        // randomized traffic with random backpressure against the reference model
        for (int i = 0; i < 400; i++) begin
            a = rand_op();
            b = rand_op();
            step(1'b0, 1'($urandom_range(0, 3) != 0), a, b, ref_mul(a, b),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
        for (int s = 0; s < 40 && exp_q.size() != 0; s++) idle(1'b1);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiplier_half_precision_pipe.md
Name: multiplier_half_precision_pipe

Overview:
- 3-stage pipelined IEEE-754 binary16 multiplier with valid/ready handshakes on both sides.
- Sits directly upstream of the half-precision adder in the vertex-transform datapath: it forms matrix×vector partial products that feed the adder's addend inputs.
- Uses the same number model as the adder: implicit leading 1, bias 15, no denormals, any operand with [14:0]==0 treated as zero, truncation rounding.
- An opaque tag travels alongside each operation so downstream logic can re-associate products with components.

Parameters:
TAG_W, 4, width of the pass-through tag (component/lane id).

Ports:
i_Clk  input  1  clock; all state updates on the rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Valid  input  1  upstream presents an operand pair this cycle.
o_Ready  output  1  block accepts the pair when i_Valid && o_Ready.
i_Factor1  input  16  binary16 operand A.
i_Factor2  input  16  binary16 operand B.
i_Tag  input  TAG_W  tag captured with the operands.
o_Valid  output  1  o_Product/o_Tag hold a result.
i_Ready  input  1  downstream consumes the result when o_Valid && i_Ready.
o_Product  output  16  binary16 product.
o_Tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (synchronous, active-high): all stage valid bits clear; o_Valid=0, o_Product=16'd0, o_Tag=0.
- o_Ready is combinational and equals the stage-1 enable, so it reads 1 in the cycle after reset.
- Reset mid-operation discards all in-flight items. No output is produced for them.
- Stage enables:
  - v1, v2, v3 are the stage valid bits; en3 = !v3 || i_Ready; en2 = !v2 || en3; en1 = !v1 || en2.
  - o_Ready = en1.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
- Stage valid updates: vk <= v(k-1) when enk, else it holds. v0 = i_Valid.
- Latency: exactly 3 cycles from acceptance to o_Valid when there is no backpressure. Throughput is 1 per cycle.
- Ordering: results emerge in acceptance order.
- o_Product and o_Tag remain stable while o_Valid && !i_Ready.
- Stage 1 (register and classify):
  - sign = A[15]^B[15].
  - zero flag = (A[14:0]==0) || (B[14:0]==0).
  - exponent sum es = A[14:10] + B[14:10] - 15, as 7-bit signed.
  - Latch mantissas {1,A[9:0]}, {1,B[9:0]} and the tag.
- Stage 2 (multiply): 22-bit unsigned product P = 11b × 11b. Carry sign, zero flag, es and tag forward.
- Stage 3 (normalize and pack):
  - If P[21]: mantissa = P[20:11], exponent = es+1. Else: mantissa = P[19:10], exponent = es. Extra bits are truncated.
  - If the zero flag is set: output 16'd0 (positive zero, matching the adder's zero convention).
  - Else if the final exponent is ≤ 0 (underflow): output 16'd0.
  - Else if the final exponent is ≥ 31 (overflow): output {sign, 15'h7BFF}, i.e. saturated max finite magnitude.
  - Else: output {sign, exponent[4:0], mantissa}.
- Inputs with exponent 31 (Inf/NaN) are not distinguished and are processed as normal numbers. Upstream guarantees finite operands.
- Simultaneous accept and emit in the same cycle is legal and must not lose or duplicate an item.

Decomposition:
- Shared package fp16_pkg:
  - constants FP16_BIAS=15, FP16_EXP_MAX=30, FP16_MAX_FINITE=15'h7BFF, FP16_ZERO=16'd0;
  - field-position constants SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MAN_MSB=9.
  - The adder adopts the same package.
- One sub-module is natural: fp16_mul_normalize, the combinational stage-3 logic (P, es, sign, zero → 16-bit result). It can be unit-tested exhaustively against a reference model.
- The handshake/pipeline registers stay in the top module.

Test Plan:
- Basic, no backpressure: i_Ready=1; accept 0x3C00×0x4000 (1.0×2.0) tag 1 → o_Valid exactly 3 cycles later with o_Product=0x4000, o_Tag=1.
- Normalize carry and sign: back-to-back 0x3E00×0x3E00 (1.5×1.5) → 0x4080; 0xC200×0x3800 (−3×0.5) → 0xBE00 on consecutive cycles, in order.
- Zero and underflow: 0x0000×0x4000 → 0x0000; 0x8000×0xC000 → 0x0000; 0x0400×0x0400 (2^−14 squared) → 0x0000.
- Overflow saturation:
  - 0x7800×0x4000 (32768×2) → 0x7BFF.
  - 0xF800×0x4000 → 0xFBFF.
  - Boundary 0x7800×0x3C00 → 0x7800, unchanged.
- Backpressure: stream tags 0..5 with i_Valid=1 and hold i_Ready=0:
  - exactly 3 items are accepted, then o_Ready=0;
  - o_Product stays stable while stalled;
  - releasing i_Ready delivers tags 0..5 in order with no loss or duplication.
- Reset mid-stream: assert i_Reset for 1 cycle with 3 items in flight → next cycle o_Valid=0, o_Product=0, o_Ready=1; no stale results appear afterwards.
